// File: rtl/acl_pkg.sv
// Shared definitions for the accelerometer sampler: ADXL362 command bytes,
// SPI frame layouts, acl_data field positions and the FSM state encodings.
package acl_pkg;

  // ADXL362 register map subset
  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  // SPI frame geometry; frames are MSB-aligned in a FRAME_W register
  localparam int unsigned FRAME_W   = 40;
  localparam int unsigned BITS_W    = 6;
  localparam int unsigned CFG_BITS  = 24;
  localparam int unsigned READ_BITS = 40;

  localparam logic [FRAME_W-1:0] CFG_FRAME  = {CMD_WRITE, REG_POWER_CTL, PWR_MEASURE, 16'h0000};
  localparam logic [FRAME_W-1:0] READ_FRAME = {CMD_READ, REG_XDATA, 24'h000000};

  // Raw axis byte MSB positions inside the received READ frame
  localparam int unsigned X_RAW_MSB = 23;
  localparam int unsigned Y_RAW_MSB = 15;
  localparam int unsigned Z_RAW_MSB = 7;

  // acl_data layout: {X[4:0], Y[4:0], Z[4:0]}
  localparam int unsigned ACL_W   = 15;
  localparam int unsigned FIELD_W = 5;
  localparam int unsigned X_LSB   = 10;
  localparam int unsigned Y_LSB   = 5;
  localparam int unsigned Z_LSB   = 0;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_CFG,
    ST_GAP_CFG,
    ST_READ,
    ST_UPDATE,
    ST_WAIT
  } acl_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_LOW,
    SPI_HIGH,
    SPI_TAIL
  } spi_state_e;

endpackage

// File: rtl/acl_spi_sampler_if.sv
// Sensor-side bus of the sampler: SPI pins plus the packed sample output.
//   sclk, mosi, cs_n : SPI mode 0 master outputs
//   miso             : SPI data from the sensor
//   acl_data         : {X[4:0], Y[4:0], Z[4:0]} signed fields
//   data_valid       : one-cycle pulse when acl_data updates
interface acl_spi_sampler_if;
  import acl_pkg::*;

  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_n;
  logic [ACL_W-1:0] acl_data;
  logic             data_valid;

  modport master (
    output sclk, mosi, cs_n, acl_data, data_valid,
    input  miso
  );

  modport slave (
    input  sclk, mosi, cs_n, acl_data, data_valid,
    output miso
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode 0 master shifter. On a start pulse it drops cs_n, shifts out
// n_bits of tx_data MSB first (tx_data is MSB-aligned), captures miso on
// every sclk rise, raises cs_n CLK_DIV_HALF clocks after the last fall and
// pulses done on that same edge.
//   clk, rst_n      : system clock, synchronous active-low reset
//   start           : begin a frame (ignored while busy)
//   tx_data, n_bits : frame to send and its length (1..40)
//   miso            : serial input
//   sclk, cs_n, mosi: SPI pins
//   busy, done      : frame in progress / frame finished pulse
//   rx_data         : received bits, last bit in rx_data[0]
module spi_shift_engine
  import acl_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic [BITS_W-1:0]  n_bits,
  input  logic               miso,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_data
);

  localparam int unsigned DIV_W    = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int unsigned DIV_LAST = (CLK_DIV_HALF > 0) ? CLK_DIV_HALF - 1 : 0;

  spi_state_e         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic [BITS_W-1:0]  len_q, len_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               div_end_c;

  assign div_end_c = (div_q == DIV_W'(DIV_LAST));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SPI_IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Half-period sequencing: LOW (lead-in or low phase), HIGH, TAIL (cs hold)
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    len_d   = len_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        if (start) begin
          state_d = SPI_LOW;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[FRAME_W-1];
          shreg_d = {tx_data[FRAME_W-2:0], 1'b0};
          rx_d    = '0;
          bits_d  = '0;
          len_d   = n_bits;
          div_d   = '0;
        end
      end
      SPI_LOW: begin
        if (div_end_c) begin
          state_d = SPI_HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[FRAME_W-2:0], miso};
          bits_d  = bits_q + 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SPI_HIGH: begin
        if (div_end_c) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bits_q == len_q) begin
            state_d = SPI_TAIL;
          end else begin
            state_d = SPI_LOW;
            mosi_d  = shreg_q[FRAME_W-1];
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SPI_TAIL: begin
        if (div_end_c) begin
          state_d = SPI_IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = SPI_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != SPI_IDLE);
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule

// File: rtl/acl_spi_sampler.sv
// ADXL362 sampler: waits for sensor power-up, writes POWER_CTL once, then
// burst-reads XDATA/YDATA/ZDATA every SAMPLE_PERIOD clocks and publishes
// the top five bits of each axis as a signed field of acl_data.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : SPI pins (sclk, mosi, miso, cs_n), acl_data, data_valid
module acl_spi_sampler
  import acl_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF  = 50,
  parameter int unsigned POWERUP_WAIT  = 1_000_000,
  parameter int unsigned SAMPLE_PERIOD = 10_000_000,
  parameter int unsigned CS_GAP        = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  acl_spi_sampler_if.master bus
);

  localparam int unsigned CNT_MAX  = (POWERUP_WAIT > CS_GAP) ? POWERUP_WAIT : CS_GAP;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned PU_LAST  = (POWERUP_WAIT > 0) ? POWERUP_WAIT - 1 : 0;
  localparam int unsigned GAP_LAST = (CS_GAP > 0) ? CS_GAP - 1 : 0;
  localparam int unsigned PER_LAST = (SAMPLE_PERIOD > 0) ? SAMPLE_PERIOD - 1 : 0;

  acl_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic               start_q, start_d;
  logic [ACL_W-1:0]   acl_q, acl_d;
  logic               valid_q, valid_d;

  logic [FRAME_W-1:0] spi_tx;
  logic [BITS_W-1:0]  spi_bits;
  logic [FRAME_W-1:0] spi_rx;
  logic               spi_busy;
  logic               spi_done;
  logic               spi_sclk;
  logic               spi_cs_n;
  logic               spi_mosi;
  logic               unused_rx;

  // Frame selection follows the state the start pulse was issued for
  assign spi_tx   = (state_q == ST_CFG) ? CFG_FRAME : READ_FRAME;
  assign spi_bits = (state_q == ST_CFG) ? BITS_W'(CFG_BITS) : BITS_W'(READ_BITS);

  spi_shift_engine #(
    .CLK_DIV_HALF (CLK_DIV_HALF)
  ) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_q),
    .tx_data (spi_tx),
    .n_bits  (spi_bits),
    .miso    (bus.miso),
    .sclk    (spi_sclk),
    .cs_n    (spi_cs_n),
    .mosi    (spi_mosi),
    .busy    (spi_busy),
    .done    (spi_done),
    .rx_data (spi_rx)
  );

  // Command echo bytes and the low three bits of each axis are discarded
  assign unused_rx = ^{spi_rx[FRAME_W-1:X_RAW_MSB+1],
                       spi_rx[X_RAW_MSB-FIELD_W:Y_RAW_MSB+1],
                       spi_rx[Y_RAW_MSB-FIELD_W:Z_RAW_MSB+1],
                       spi_rx[Z_RAW_MSB-FIELD_W:0]};

  // State, timers and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_POWERUP;
      cnt_q    <= '0;
      period_q <= '0;
      start_q  <= 1'b0;
      acl_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      start_q  <= start_d;
      acl_q    <= acl_d;
      valid_q  <= valid_d;
    end
  end

  // Sequencing; period_q counts from the clock a READ is launched and
  // saturates so an overlong transaction only delays the next READ by CS_GAP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    acl_d    = acl_q;
    valid_d  = 1'b0;
    period_d = (period_q == PER_W'(PER_LAST)) ? period_q : period_q + 1'b1;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q >= CNT_W'(PU_LAST)) begin
          state_d = ST_CFG;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CFG: begin
        if (spi_done) begin
          state_d = ST_GAP_CFG;
          cnt_d   = '0;
        end
      end
      ST_GAP_CFG: begin
        if (cnt_q >= CNT_W'(GAP_LAST)) begin
          state_d  = ST_READ;
          start_d  = 1'b1;
          period_d = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        // acl_data/data_valid register on the edge that enters UPDATE
        if (spi_done) begin
          state_d = ST_UPDATE;
          valid_d = 1'b1;
          acl_d[X_LSB +: FIELD_W] = spi_rx[X_RAW_MSB -: FIELD_W];
          acl_d[Y_LSB +: FIELD_W] = spi_rx[Y_RAW_MSB -: FIELD_W];
          acl_d[Z_LSB +: FIELD_W] = spi_rx[Z_RAW_MSB -: FIELD_W];
        end
      end
      ST_UPDATE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (cnt_q < CNT_W'(GAP_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_q >= CNT_W'(GAP_LAST)) && (period_q == PER_W'(PER_LAST)) && !spi_busy) begin
          state_d  = ST_READ;
          start_d  = 1'b1;
          period_d = '0;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.sclk       = spi_sclk;
  assign bus.cs_n       = spi_cs_n;
  assign bus.mosi       = spi_mosi;
  assign bus.acl_data   = acl_q;
  assign bus.data_valid = valid_q;

endmodule
